seq_mult: RTL and testbench
===========================

Name: seq_mult

Overview:
- Parametrised sequential shift-add multiplier; next generation of the team's 4-bit combinational array multiplier.
- Computes one partial product per clock, so area is one WIDTH-bit adder instead of WIDTH-1 ripple-carry stages.
- Valid/ready handshake on both the operand side and the result side, so it can sit between pipelined datapath stages.

Parameters:
- WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden by users).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- out_valid  output  1  product p valid (high only in DONE)
- out_ready  input  1  downstream accepts p
- p  output  2*WIDTH  product
- busy  output  1  high in CALC

Behaviour:
- Reset: rst_n low at a rising edge forces state=IDLE, in_ready=1, out_valid=0, busy=0, p=0, counter=0, internal registers=0.
- Reset mid-operation (CALC or DONE) aborts the operation with the same result; the partial product is discarded.
- Three states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a into the multiplicand register, load acc={WIDTH'b0, b}, set counter=WIDTH, go to CALC.
- CALC, each edge:
  - If acc[0]=1, add the multiplicand to acc[2W-1:W] with a WIDTH+1-bit sum (carry kept).
  - Shift {carry, acc} right by 1.
  - Decrement the counter.
  - When the counter reaches 0 on this edge, go to DONE and load p with the final acc.
- Latency: operands accepted at edge N; out_valid=1 after edge N+WIDTH.
- DONE:
  - out_valid=1; p holds stable.
  - On an edge with out_ready=1, go to IDLE. out_valid drops and in_ready rises after that edge.
  - With out_ready=0, DONE is held indefinitely with no change to p.
- p holds the last product until the next DONE entry; it is not cleared in IDLE.
- in_valid outside IDLE is ignored and causes no error. a and b may change freely after acceptance.
- No overlap: a new operand pair cannot be accepted in the same cycle a result is consumed. Throughput is one product per WIDTH+2 cycles with out_ready tied high.
- Width rules:
  - Unsigned result is exact: max (2^W-1)^2 fits in 2W bits.
  - No overflow is possible.
  - Zero operands take the full WIDTH cycles; there is no early termination.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN
- Defined:
  - Adds input port signed_mode (1 bit), sampled together with the operands at acceptance.
  - When signed_mode=1, a and b are two's complement. The block multiplies the magnitudes and negates the 2W-bit result at DONE entry if sign(a) XOR sign(b).
  - -2^(W-1) * -2^(W-1) = +2^(2W-2) fits in the range.
  - Latency is unchanged.
- Not defined: the signed_mode port is absent and all operands are unsigned.

Test Plan:
- WIDTH=4, a=15, b=15, out_ready=1 -> out_valid rises exactly 4 edges after acceptance, p=8'hE1 (225); in_ready returns the cycle after.
- WIDTH=8, a=0, b=8'hA5 -> p=16'h0000 after 8 cycles. Then a=8'hFF, b=8'h01 -> p=16'h00FF, proving p updates only at DONE.
- WIDTH=8, a=200, b=100, out_ready=0 for 10 cycles after out_valid:
  - p=16'h4E20 stays stable and out_valid stays high.
  - in_valid pulses during the stall are ignored.
  - Release out_ready -> IDLE after exactly one handshake edge.
- WIDTH=8, accept a=12, b=13, assert rst_n=0 at CALC cycle 3 -> next edge: in_ready=1, out_valid=0, busy=0, p=0. No result is produced later.
- Back-to-back with in_valid and out_ready held high, random 1000 pairs (WIDTH=8) -> each p equals a*b, and acceptances are spaced exactly WIDTH+2 cycles apart.
- SEQ_MULT_SIGNED_EN, WIDTH=4, signed_mode=1:
  - a=4'b1000 (-8), b=4'b0111 (7) -> p=8'hC8 (-56).
  - a=-8, b=-8 -> p=8'h40 (64).
  - signed_mode=0 with a=8, b=7 -> p=8'h38.

Source files
------------

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one partial product per clock, valid/ready on both sides.
// Optional signed operands when SEQ_MULT_SIGNED_EN is defined (adds signed_mode port).
module seq_mult #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic                 signed_mode,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [WIDTH:0]       sum;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;
  logic                 neg_in;
  logic                 last_iter;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v,
                                                     input logic             negate);
    return negate ? (~v + 1'b1) : v;
  endfunction

`ifdef SEQ_MULT_SIGNED_EN
  // The most negative operand maps to 2^(W-1), which still fits as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic             is_signed);
    return (is_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  assign a_mag  = magnitude(a, signed_mode);
  assign b_mag  = magnitude(b, signed_mode);
  assign neg_in = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign neg_in = 1'b0;
`endif

  // One shift-add step: carry out of the upper half is shifted back into the MSB.
  always_comb begin
    sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    acc_nxt   = {sum, acc[WIDTH-1:1]};
    last_iter = (cnt == CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= a_mag;
            acc   <= {{WIDTH{1'b0}}, b_mag};
            cnt   <= CNT_W'(WIDTH);
            neg   <= neg_in;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          if (last_iter) p <= apply_sign(acc_nxt, neg);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: WIDTH=8 instance with scoreboard plus a WIDTH=4 instance
// for the small-width and (when SEQ_MULT_SIGNED_EN is defined) signed cases.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] p;

  logic        iv4, ir4, ov4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
`ifdef SEQ_MULT_SIGNED_EN
  logic        sm4;
  logic        sm8;
`endif

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [15:0] vp;
  } vec_t;

  always #5 clk = ~clk;

  seq_mult #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_mode(sm8),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
  );

  seq_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_mode(sm4),
`endif
    .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(1'b1), .p(p4), .busy(busy4)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one operand pair and push its expected product when the handshake is seen.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic [15:0] exp);
    int n = 0;
    bit got = 1'b0;
    @(posedge clk); #1;
    a = ta; b = tb_; in_valid = 1'b1;
    while (!got && n < 50) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        got = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("accept", 32'(got), 32'd1);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run4(input logic [3:0] ta, input logic [3:0] tb_, input logic [7:0] exp,
                      input string nm);
    int n = 0;
    int lat = 0;
    bit got = 1'b0;
    @(posedge clk); #1;
    a4 = ta; b4 = tb_; iv4 = 1'b1;
    while (!got && n < 50) begin
      got = ir4;
      @(posedge clk); #1;
      n++;
    end
    iv4 = 1'b0;
    while (!ov4 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_lat"}, 32'(lat), 32'd4);
    check({nm, "_p"}, 32'(p4), 32'(exp));
    @(posedge clk); #1;
    check({nm, "_ready_back"}, {30'd0, ir4, ov4}, 32'b10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic [15:0] prev;
    int lat;
    int cyc;
    int last;
    int nacc;
    bit saw;

    vecs[0] = '{8'h00, 8'hA5, 16'h0000};
    vecs[1] = '{8'hFF, 8'h01, 16'h00FF};
    vecs[2] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[3] = '{8'h0C, 8'h0D, 16'h009C};
    vecs[4] = '{8'h80, 8'h02, 16'h0100};
    vecs[5] = '{8'h01, 8'hFF, 16'h00FF};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    iv4 = 1'b0; a4 = '0; b4 = '0;
`ifdef SEQ_MULT_SIGNED_EN
    sm4 = 1'b0; sm8 = 1'b0;
`endif

    fork
      forever begin
        @(negedge clk);
        if (!rst_n) exp_q.delete();
        else if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
          else check("sb_p", 32'(p), 32'(exp_q.pop_front()));
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {28'd0, in_ready, out_valid, busy, 1'b0}, {28'd0, 4'b1000});
    check("rst_p", 32'(p), 32'd0);
    check("rst_p4", 32'(p4), 32'd0);
    rst_n = 1'b1;

    run4(4'd15, 4'd15, 8'hE1, "w4_15x15");

    prev = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].va, vecs[i].vb, vecs[i].vp);
      check("p_hold_calc", 32'(p), 32'(prev));
      check("busy_calc", 32'(busy), 32'd1);
      wait_valid(lat);
      check("latency", 32'(lat), 32'd8);
      check("vec_p", 32'(p), 32'(vecs[i].vp));
      @(posedge clk); #1;
      check("ready_back", {30'd0, in_ready, out_valid}, 32'b10);
      prev = vecs[i].vp;
    end

    out_ready = 1'b0;
    send(8'd200, 8'd100, 16'h4E20);
    wait_valid(lat);
    check("stall_lat", 32'(lat), 32'd8);
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
      check("stall_hold", {15'd0, out_valid, in_ready, p}, {15'd0, 1'b1, 1'b0, 16'h4E20});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release", {29'd0, in_ready, out_valid, busy}, 32'b100);

    send(8'd12, 8'd13, 16'h009C);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_state", {29'd0, in_ready, out_valid, busy}, 32'b100);
    check("abort_p", 32'(p), 32'd0);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    check("abort_no_result", 32'(saw), 32'd0);
    check("abort_queue", 32'(exp_q.size()), 32'd0);

    a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
    cyc = 0; last = -1; nacc = 0;
    while (nacc < 1000 && cyc < 20000) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(16'(a) * 16'(b));
        if (last >= 0) check("b2b_spacing", 32'(cyc - last), 32'd10);
        last = cyc;
        nacc++;
        @(posedge clk); #1;
        a = 8'($urandom); b = 8'($urandom);
      end else begin
        @(posedge clk); #1;
      end
      cyc++;
    end
    in_valid = 1'b0;
    check("b2b_count", 32'(nacc), 32'd1000);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_drain", 32'(exp_q.size()), 32'd0);

`ifdef SEQ_MULT_SIGNED_EN
    sm4 = 1'b1;
    run4(4'b1000, 4'b0111, 8'hC8, "s_m8x7");
    run4(4'b1000, 4'b1000, 8'h40, "s_m8xm8");
    sm4 = 1'b0;
    run4(4'd8, 4'd7, 8'h38, "u_8x7");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
